unified_mem: RTL and testbench
==============================

# unified_mem

Shared data/instruction memory for the next-generation CPU top level. It replaces the separate instruction ROM and data RAM with one parametrised single-port array served to NCH requester channels, for example instruction fetch and load/store. Channels are arbitrated round-robin. Each channel keeps a req/gnt/valid handshake that generalises the existing ready/valid memory ports. Read latency is configurable, and out-of-range accesses are reported.

## Interface
- DWIDTH, 16: data word width in bits.
- AWIDTH, 16: address width per channel, in words.
- DEPTH_LOG2, 10: array holds 2^DEPTH_LOG2 words. Must satisfy DEPTH_LOG2 ≤ AWIDTH.
- NCH, 2: number of requester channels, 1..8. Channel 0 is the instruction port by convention.
- RD_LAT, 1: cycles from grant to valid_o, 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  NCH  per-channel request; held until granted.
- wen_i  input  NCH  per-channel write enable; 1 = write, 0 = read.
- addr_i  input  NCH*AWIDTH  per-channel word address; channel k occupies bits [k*AWIDTH +: AWIDTH].
- wdata_i  input  NCH*DWIDTH  per-channel write data, packed the same way as addr_i.
- gnt_o  output  NCH  one-hot grant, combinational; at most one bit set.
- valid_o  output  NCH  one-cycle completion pulse per channel.
- rdata_o  output  NCH*DWIDTH  per-channel response data, held between pulses.
- err_o  output  NCH  per-channel out-of-range flag, qualified by valid_o.

## Operation
- **Request rules.** A requester asserts req_i[k] with wen/addr/wdata stable. It holds all of them until the cycle where gnt_o[k]=1. The transfer occurs at that rising edge.
- **Arbitration.**
  - Round-robin pointer rr (width clog2(NCH), reset 0).
  - The grant goes to the first requesting channel scanning rr, rr+1, … modulo NCH.
  - After a grant to channel g, rr becomes (g+1) mod NCH. With no grant, rr is unchanged.
- **Range check.** Address is in range when addr bits [AWIDTH-1:DEPTH_LOG2] are all zero. The array index is addr[DEPTH_LOG2-1:0].
- **Write.**
  - In range: the array word is updated at the grant edge.
  - Out of range: no array update.
  - The response carries rdata = wdata and err = out-of-range.
- **Read.**
  - In range: the response carries the array word as of the grant edge, including a write granted in an earlier cycle.
  - Out of range: rdata = 0, err = 1.
- **Response pipeline.** RD_LAT stages. Each stage holds {vld, channel id, data, err}.
  - The final stage drives valid_o[id] = 1 for one cycle and loads rdata_o/err_o for that channel only.
  - Other channels' rdata_o/err_o hold their values.
- **Memory contents.** The array is not reset. It has no initialisation requirement beyond the simulation-only $readmemh hook used by the existing ROM flow.
- **Reset.** Asserting rst_n low mid-operation:
  - clears the pipeline; in-flight responses are discarded and never pulse;
  - clears rr to 0 and all outputs to 0;
  - leaves array contents undefined-but-retained.

## Timing
- Reset values: gnt_o=0 (while rst_n low), valid_o=0, rdata_o=0, err_o=0, rr=0.
- gnt_o is a combinational function of req_i and rr. There is no request-to-grant bubble: one grant per cycle at full throughput.
- Grant at edge T → valid_o pulses in the cycle following edge T+RD_LAT-1. With RD_LAT=1 this is the cycle immediately after the grant.
- Back-to-back grants to the same channel yield back-to-back valid_o pulses, in order.
- Read-after-write:
  - A write granted at edge T is visible to a read granted at edge T+1 or later.
  - A read and a write cannot be granted at the same edge.
- Requests that drop req_i before being granted are not served. This is a protocol violation and the behaviour is not checked beyond "no grant".
- NCH=1: gnt_o = req_i[0]. rr is constant 0.

## Test plan
- **Reset defaults.** Hold rst_n=0 with random req_i → gnt_o=0, valid_o=0, rdata_o=0, err_o=0. Release → first grant goes to the lowest requesting channel index.
- **Write/read, default parameters (NCH=2, RD_LAT=1).**
  - Ch0 writes 0xBEEF to addr 0x0005 → gnt_o=01, then valid_o=01 one cycle later.
  - Ch1 then reads 0x0005 → valid_o=10, rdata_o[ch1]=0xBEEF, err_o[ch1]=0.
- **Round-robin fairness.** NCH=4, all req_i held high for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Then only ch2 requests → ch2 is granted every cycle.
- **Latency sweep.** RD_LAT=3, ch0 reads at edges T, T+1 → valid_o[0] pulses at cycles T+3 and T+4, with the correct data in order. rdata_o[1] is unchanged.
- **Out of range.** DEPTH_LOG2=10:
  - Write 0x1234 to 0x0400 → err=1, array word 0x000 unchanged on readback.
  - Read 0x0400 → rdata=0, err=1.
- **Reset mid-flight.** RD_LAT=4, grant a read, assert rst_n low 2 cycles later → no valid_o pulse ever appears for it. After release, rr=0 and a new read returns the correct data.

Source files
------------

// File: rtl/unified_mem.sv
// Shared single-port instruction/data memory served to NCH requester channels.
// Round-robin arbitration, RD_LAT-deep response pipeline, out-of-range reporting.
module unified_mem #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int NCH        = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req_i,
    input  logic [NCH-1:0]           wen_i,
    input  logic [NCH*AWIDTH-1:0]    addr_i,
    input  logic [NCH*DWIDTH-1:0]    wdata_i,
    output logic [NCH-1:0]           gnt_o,
    output logic [NCH-1:0]           valid_o,
    output logic [NCH*DWIDTH-1:0]    rdata_o,
    output logic [NCH-1:0]           err_o
);
    localparam int IDW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [IDW-1:0]        rr;
    logic [IDW-1:0]        rr_nxt;
    logic [NCH-1:0]        gnt;
    logic [IDW-1:0]        gid;
    logic                  found;
    logic                  any_gnt;

    logic                  sel_wen;
    logic [AWIDTH-1:0]     sel_addr;
    logic [DWIDTH-1:0]     sel_wdata;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] mem_idx;

    logic [DWIDTH-1:0]     mem [DEPTH];

    logic                  stg_vld;
    logic [IDW-1:0]        stg_id;
    logic [DWIDTH-1:0]     stg_dat;
    logic                  stg_err;

    logic                  fin_vld;
    logic [IDW-1:0]        fin_id;
    logic [DWIDTH-1:0]     fin_dat;
    logic                  fin_err;

    // Arbitration: first requester scanning rr, rr+1, ... modulo NCH
    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        gid   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr) + i) % NCH;
            if (!found && req_i[idx]) begin
                gnt[idx] = 1'b1;
                gid      = IDW'(idx);
                found    = 1'b1;
            end
        end
        rr_nxt = IDW'((int'(gid) + 1) % NCH);
    end

    assign gnt_o   = rst_n ? gnt : '0;
    assign any_gnt = found & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0;
        end else if (any_gnt) begin
            rr <= rr_nxt;
        end
    end

    assign sel_wen   = wen_i[gid];
    assign sel_addr  = addr_i[gid*AWIDTH +: AWIDTH];
    assign sel_wdata = wdata_i[gid*DWIDTH +: DWIDTH];
    assign in_range  = (sel_addr >> DEPTH_LOG2) == '0;
    assign mem_idx   = sel_addr[DEPTH_LOG2-1:0];

    // Array access at the grant edge; contents are never reset
    always_ff @(posedge clk) begin
        if (any_gnt && sel_wen && in_range) begin
            mem[mem_idx] <= sel_wdata;
        end
    end

    assign stg_vld = any_gnt;
    assign stg_id  = gid;
    assign stg_err = !in_range;
    assign stg_dat = sel_wen ? sel_wdata : (in_range ? mem[mem_idx] : '0);

    // Stage p0..p(RD_LAT-2): intermediate response stages ahead of the output registers
    generate
        if (RD_LAT == 1) begin : g_nopipe
            assign fin_vld = stg_vld;
            assign fin_id  = stg_id;
            assign fin_dat = stg_dat;
            assign fin_err = stg_err;
        end else begin : g_pipe
            localparam int NP = RD_LAT - 1;
            logic              vld_p [NP];
            logic [IDW-1:0]    id_p  [NP];
            logic [DWIDTH-1:0] dat_p [NP];
            logic              err_p [NP];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < NP; k++) vld_p[k] <= 1'b0;
                end else begin
                    vld_p[0] <= stg_vld;
                    for (int k = 1; k < NP; k++) vld_p[k] <= vld_p[k-1];
                end
            end

            always_ff @(posedge clk) begin
                id_p[0]  <= stg_id;
                dat_p[0] <= stg_dat;
                err_p[0] <= stg_err;
                for (int k = 1; k < NP; k++) begin
                    id_p[k]  <= id_p[k-1];
                    dat_p[k] <= dat_p[k-1];
                    err_p[k] <= err_p[k-1];
                end
            end

            assign fin_vld = vld_p[NP-1];
            assign fin_id  = id_p[NP-1];
            assign fin_dat = dat_p[NP-1];
            assign fin_err = err_p[NP-1];
        end
    endgenerate

    // Output stage: pulse valid and update only the responding channel's data/err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= '0;
            rdata_o <= '0;
            err_o   <= '0;
        end else begin
            valid_o <= '0;
            if (fin_vld) begin
                valid_o[fin_id]                  <= 1'b1;
                rdata_o[fin_id*DWIDTH +: DWIDTH] <= fin_dat;
                err_o[fin_id]                    <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: three instances cover default parameters,
// NCH=4/RD_LAT=3 arbitration and latency, and RD_LAT=4 reset mid-flight.
module tb_unified_mem;
    logic clk;
    logic rst_n;
    logic rst_c;

    logic [1:0]  req_a, wen_a, gnt_a, valid_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;

    logic [3:0]  req_b, wen_b, gnt_b, valid_b, err_b;
    logic [63:0] addr_b, wdata_b, rdata_b;

    logic [1:0]  req_c, wen_c, gnt_c, valid_c, err_c;
    logic [31:0] addr_c, wdata_c, rdata_c;

    int ntests = 0;
    int nfail  = 0;

    unified_mem #(.NCH(2), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_i(req_a), .wen_i(wen_a), .addr_i(addr_a),
        .wdata_i(wdata_a), .gnt_o(gnt_a), .valid_o(valid_a), .rdata_o(rdata_a), .err_o(err_a)
    );

    unified_mem #(.NCH(4), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .req_i(req_b), .wen_i(wen_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .gnt_o(gnt_b), .valid_o(valid_b), .rdata_o(rdata_b), .err_o(err_b)
    );

    unified_mem #(.NCH(2), .RD_LAT(4)) u_c (
        .clk(clk), .rst_n(rst_c), .req_i(req_c), .wen_i(wen_c), .addr_i(addr_c),
        .wdata_i(wdata_c), .gnt_o(gnt_c), .valid_o(valid_c), .rdata_o(rdata_c), .err_o(err_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single-channel transfer on instance A (RD_LAT=1): grant now, response next cycle
    task automatic op_a(input int ch, input logic wen, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_d, input logic exp_e);
        addr_a[ch*16 +: 16]  = addr;
        wdata_a[ch*16 +: 16] = wdata;
        wen_a[ch]            = wen;
        req_a                = 2'b00;
        req_a[ch]            = 1'b1;
        @(negedge clk);
        check("a_op_gnt", 64'(gnt_a), 64'(2'b01 << ch));
        @(posedge clk); #1;
        req_a = 2'b00;
        check("a_op_valid", 64'(valid_a), 64'(2'b01 << ch));
        check("a_op_rdata", 64'(rdata_a[ch*16 +: 16]), 64'(exp_d));
        check("a_op_err", 64'(err_a[ch]), 64'(exp_e));
    endtask

    initial begin
        logic seen;
        rst_n = 1'b1; rst_c = 1'b1;
        req_a = '0; wen_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; wen_b = '0; addr_b = '0; wdata_b = '0;
        req_c = '0; wen_c = '0; addr_c = '0; wdata_c = '0;
        #2;
        rst_n = 1'b0; rst_c = 1'b0;
        req_a = 2'b11; req_b = 4'b1011; req_c = 2'b10;

        // Reset defaults with requests active
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt_a", 64'(gnt_a), 64'd0);
        check("rst_valid_a", 64'(valid_a), 64'd0);
        check("rst_rdata_a", 64'(rdata_a), 64'd0);
        check("rst_err_a", 64'(err_a), 64'd0);
        check("rst_gnt_b", 64'(gnt_b), 64'd0);
        check("rst_rdata_b", rdata_b, 64'd0);
        check("rst_gnt_c", 64'(gnt_c), 64'd0);
        check("rst_valid_c", 64'(valid_c), 64'd0);

        // Release: ch0 writes 0xBEEF to 5, ch1 reads 5
        req_b = '0; req_c = '0;
        wen_a = 2'b01;
        addr_a = {16'h0005, 16'h0005};
        wdata_a = {16'h0000, 16'hBEEF};
        req_a = 2'b11;
        rst_n = 1'b1; rst_c = 1'b1;
        #1;
        check("first_gnt_lowest", 64'(gnt_a), 64'(2'b01));
        @(posedge clk); #1;
        req_a[0] = 1'b0;
        check("wr_valid", 64'(valid_a), 64'(2'b01));
        check("wr_echo", 64'(rdata_a[15:0]), 64'h BEEF);
        check("wr_err", 64'(err_a[0]), 64'd0);
        @(negedge clk);
        check("rd_gnt", 64'(gnt_a), 64'(2'b10));
        @(posedge clk); #1;
        req_a = 2'b00;
        check("rd_valid", 64'(valid_a), 64'(2'b10));
        check("rd_data", 64'(rdata_a[31:16]), 64'h BEEF);
        check("rd_err", 64'(err_a[1]), 64'd0);
        check("rd_ch0_hold", 64'(rdata_a[15:0]), 64'h BEEF);

        // Out-of-range and top-of-array accesses
        op_a(0, 1'b1, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0);
        op_a(0, 1'b1, 16'h0400, 16'h1234, 16'h1234, 1'b1);
        op_a(0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0);
        op_a(1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1);
        op_a(1, 1'b1, 16'h03FF, 16'h7777, 16'h7777, 1'b0);
        op_a(0, 1'b0, 16'h03FF, 16'h0000, 16'h7777, 1'b0);
        op_a(1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);

        // Round-robin on instance B: all four channels write, held for 8 cycles
        wen_b   = 4'hF;
        addr_b  = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        wdata_b = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        req_b   = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr_gnt%0d", i), 64'(gnt_b), 64'(4'b0001 << (i % 4)));
            @(posedge clk); #1;
        end
        req_b = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rr_ch2_gnt%0d", i), 64'(gnt_b), 64'(4'b0100));
            @(posedge clk); #1;
        end
        req_b = '0; wen_b = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rr_ch1_echo", 64'(rdata_b[31:16]), 64'h1001);
        check("rr_idle_valid", 64'(valid_b), 64'd0);

        // Latency sweep on B: ch0 reads 0x12 then 0x13 back to back
        addr_b[15:0] = 16'h0012;
        req_b = 4'b0001;
        @(negedge clk);
        check("lat_gnt", 64'(gnt_b), 64'(4'b0001));
        @(posedge clk); #1;
        addr_b[15:0] = 16'h0013;
        check("lat_t0_valid", 64'(valid_b), 64'd0);
        @(posedge clk); #1;
        req_b = '0;
        check("lat_t1_valid", 64'(valid_b), 64'd0);
        @(posedge clk); #1;
        check("lat_t2_valid", 64'(valid_b), 64'(4'b0001));
        check("lat_t2_data", 64'(rdata_b[15:0]), 64'h1002);
        @(posedge clk); #1;
        check("lat_t3_valid", 64'(valid_b), 64'(4'b0001));
        check("lat_t3_data", 64'(rdata_b[15:0]), 64'h1003);
        check("lat_ch1_hold", 64'(rdata_b[31:16]), 64'h1001);
        @(posedge clk); #1;
        check("lat_t4_valid", 64'(valid_b), 64'd0);

        // Instance C (RD_LAT=4): write 0xCAFE to 7
        wen_c = 2'b01;
        addr_c = {16'h0007, 16'h0007};
        wdata_c = {16'h0000, 16'hCAFE};
        req_c = 2'b01;
        @(negedge clk);
        check("c_wr_gnt", 64'(gnt_c), 64'(2'b01));
        @(posedge clk); #1;
        req_c = '0; wen_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check("c_wr_early", 64'(valid_c), 64'd0);
        @(posedge clk); #1;
        check("c_wr_valid", 64'(valid_c), 64'(2'b01));
        check("c_wr_echo", 64'(rdata_c[15:0]), 64'h CAFE);

        // Read granted, then reset two cycles later: response must never appear
        req_c = 2'b01;
        @(posedge clk); #1;
        req_c = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_c = 1'b0;
        #3;
        check("c_rst_valid", 64'(valid_c), 64'd0);
        check("c_rst_rdata", 64'(rdata_c), 64'd0);
        @(posedge clk); #1;
        rst_c = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | (|valid_c);
        end
        check("c_no_pulse", 64'(seen), 64'd0);

        // After reset rr is 0: both request, ch0 wins
        req_c = 2'b11;
        @(negedge clk);
        check("c_rr_gnt", 64'(gnt_c), 64'(2'b01));
        @(posedge clk); #1;
        req_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check("c_rd_valid", 64'(valid_c), 64'(2'b01));
        check("c_rd_data", 64'(rdata_c[15:0]), 64'h CAFE);
        check("c_rd_err", 64'(err_c[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
